// File: rtl/counter_sampler.sv
// counter_sampler: bus initiator that periodically drains the four performance
// counters into a ring buffer in data memory, optionally clearing each counter
// after it has been read. Every sample is a fixed sequence of single-beat
// transactions: RD counter, WR buffer word, and optionally WR counter = 0.
// Bus outputs are registered and computed from the next state, so a request
// appears in the cycle after its trigger or the previous response.
module counter_sampler #(
    parameter int unsigned SAMPLE_PERIOD   = 1000,
    parameter logic [31:0] CTR_BASE        = 32'h0000_0050,
    parameter logic [31:0] BUF_BASE        = 32'h0000_1000,
    parameter int unsigned BUF_WORDS       = 64,
    parameter bit          CLEAR_ON_SAMPLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_now,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic [31:0] samples_taken,
    output logic        wrapped
);

    localparam int unsigned       PTR_W      = $clog2(BUF_WORDS);
    localparam logic [31:0]       TIMER_LAST = 32'(SAMPLE_PERIOD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(BUF_WORDS - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        CLR  = 2'd3
    } state_t;

    // Architectural state
    state_t           state_r;
    logic [1:0]       idx_r;
    logic [PTR_W-1:0] ptr_r;
    logic [31:0]      timer_r;
    logic [31:0]      hold_r;
    logic             pend_r;
    logic             wrapped_r;
    logic [31:0]      samples_r;

    // Registered bus and status outputs
    logic [31:0]      mem_address_r;
    logic             mem_read_r;
    logic             mem_write_r;
    logic [31:0]      mem_wdata_r;
    logic             busy_r;

    // Next-state values
    state_t           state_nxt_s;
    logic [1:0]       idx_nxt_s;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [31:0]      timer_nxt_s;
    logic [31:0]      hold_nxt_s;
    logic             pend_nxt_s;
    logic             wrapped_nxt_s;
    logic [31:0]      samples_nxt_s;

    // Outcome of finishing the current counter (advance index or end sample)
    state_t           step_state_s;
    logic [1:0]       step_idx_s;
    logic [31:0]      step_samples_s;

    logic             trigger_s;

    // Next-cycle bus outputs
    logic [31:0]      mem_address_nxt_s;
    logic             mem_read_nxt_s;
    logic             mem_write_nxt_s;
    logic [31:0]      mem_wdata_nxt_s;
    logic             busy_nxt_s;

    // Address of counter i inside the MMIO window.
    function automatic logic [31:0] ctr_addr(input logic [1:0] i);
        return CTR_BASE + {30'd0, i};
    endfunction

    // Byte address of ring buffer word p.
    function automatic logic [31:0] buf_addr(input logic [PTR_W-1:0] p);
        logic [31:0] off;
        off = 32'd0;
        off[PTR_W+1:2] = p;
        return BUF_BASE + off;
    endfunction

    // Sequencer: trigger detection, transaction stepping and bookkeeping.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        ptr_nxt_s     = ptr_r;
        timer_nxt_s   = timer_r;
        hold_nxt_s    = hold_r;
        wrapped_nxt_s = wrapped_r;
        samples_nxt_s = samples_r;

        trigger_s = enable && ((timer_r == TIMER_LAST) || sample_now || pend_r);

        if (idx_r != 2'd3) begin
            step_state_s   = RD;
            step_idx_s     = idx_r + 2'd1;
            step_samples_s = samples_r;
        end else begin
            step_state_s   = IDLE;
            step_idx_s     = idx_r;
            step_samples_s = samples_r + 32'd1;
        end

        // Only one pending slot; it is consumed by the next IDLE cycle and
        // dropped whenever enable goes low.
        if (state_r == IDLE) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = enable & (pend_r | sample_now);
        end

        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    timer_nxt_s = 32'd0;
                    idx_nxt_s   = 2'd0;
                    state_nxt_s = RD;
                end else if (enable) begin
                    timer_nxt_s = timer_r + 32'd1;
                end else begin
                    timer_nxt_s = 32'd0;
                end
            end
            RD: begin
                if (mem_resp) begin
                    hold_nxt_s  = mem_rdata;
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = RD;
                end
            end
            WR: begin
                if (mem_resp) begin
                    ptr_nxt_s     = ptr_r + PTR_ONE;
                    wrapped_nxt_s = wrapped_r | (ptr_r == PTR_LAST);
                    if (CLEAR_ON_SAMPLE) begin
                        state_nxt_s = CLR;
                    end else begin
                        state_nxt_s   = step_state_s;
                        idx_nxt_s     = step_idx_s;
                        samples_nxt_s = step_samples_s;
                    end
                end else begin
                    state_nxt_s = WR;
                end
            end
            CLR: begin
                if (mem_resp) begin
                    state_nxt_s   = step_state_s;
                    idx_nxt_s     = step_idx_s;
                    samples_nxt_s = step_samples_s;
                end else begin
                    state_nxt_s = CLR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bus request for the next cycle, derived from where the FSM is going.
    always_comb begin
        mem_address_nxt_s = 32'd0;
        mem_read_nxt_s    = 1'b0;
        mem_write_nxt_s   = 1'b0;
        mem_wdata_nxt_s   = 32'd0;
        busy_nxt_s        = (state_nxt_s != IDLE);
        case (state_nxt_s)
            RD: begin
                mem_address_nxt_s = ctr_addr(idx_nxt_s);
                mem_read_nxt_s    = 1'b1;
            end
            WR: begin
                mem_address_nxt_s = buf_addr(ptr_nxt_s);
                mem_wdata_nxt_s   = hold_nxt_s;
                mem_write_nxt_s   = 1'b1;
            end
            CLR: begin
                mem_address_nxt_s = ctr_addr(idx_nxt_s);
                mem_wdata_nxt_s   = 32'd0;
                mem_write_nxt_s   = 1'b1;
            end
            default: begin
                mem_address_nxt_s = 32'd0;
                mem_read_nxt_s    = 1'b0;
                mem_write_nxt_s   = 1'b0;
                mem_wdata_nxt_s   = 32'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            ptr_r         <= '0;
            timer_r       <= 32'd0;
            hold_r        <= 32'd0;
            pend_r        <= 1'b0;
            wrapped_r     <= 1'b0;
            samples_r     <= 32'd0;
            mem_address_r <= 32'd0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_wdata_r   <= 32'd0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            ptr_r         <= ptr_nxt_s;
            timer_r       <= timer_nxt_s;
            hold_r        <= hold_nxt_s;
            pend_r        <= pend_nxt_s;
            wrapped_r     <= wrapped_nxt_s;
            samples_r     <= samples_nxt_s;
            mem_address_r <= mem_address_nxt_s;
            mem_read_r    <= mem_read_nxt_s;
            mem_write_r   <= mem_write_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    assign mem_address   = mem_address_r;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign mem_wdata     = mem_wdata_r;
    assign busy          = busy_r;
    assign samples_taken = samples_r;
    assign wrapped       = wrapped_r;

endmodule

// File: doc/counter_sampler.md
# counter_sampler

Bus-initiator block that periodically drains the performance counters in `counter_unit` into a ring buffer in data memory. It is the reading end of the counter MMIO window at `0x50`–`0x53`. On each sample it reads the four counters, writes their values to consecutive buffer words, and can optionally clear each counter by writing it. It sits on its own master port into the data-memory arbiter, alongside the pipeline's data port, so counter history can be collected without software polling.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 1000: idle cycles between automatic samples (≥2).
- `CTR_BASE`, 32'h50: address of the first counter; the four counters are at `CTR_BASE+0..3`.
- `BUF_BASE`, 32'h1000: byte address of ring buffer word 0.
- `BUF_WORDS`, 64: ring buffer depth in 32-bit words; a power of two and a multiple of 4.
- `CLEAR_ON_SAMPLE`, 1: when 1, each counter is written with 0 after it is read.

Ports:
- `clk` in 1: the single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: allows periodic and manual sampling.
- `sample_now` in 1: single-cycle manual trigger.
- `mem_resp` in 1: transaction complete, valid in the same cycle as an asserted request.
- `mem_rdata` in 32: read data, valid when `mem_resp`=1 during a read.
- `mem_address` out 32: transaction address.
- `mem_read` out 1: read request.
- `mem_write` out 1: write request.
- `mem_wdata` out 32: write data.
- `busy` out 1: high in every non-IDLE state.
- `samples_taken` out 32: number of completed samples; wraps modulo 2^32.
- `wrapped` out 1: sticky flag; buffer pointer has wrapped at least once.

## Operation
- FSM states: IDLE, RD, WR, CLR. Index register `idx` is 2 bits.
- **IDLE:** all requests are low.
  - While `enable`=1, `timer` increments each cycle.
  - A sample is triggered when `timer`==`SAMPLE_PERIOD`-1, or when `sample_now`=1 or `pend`=1.
  - On a trigger: `timer`←0, `pend`←0, `idx`←0, go to RD.
  - While `enable`=0, `timer` holds at 0 and `sample_now` is ignored.
- **RD:**
  - Drives `mem_address`=`CTR_BASE`+`idx`, `mem_read`=1.
  - On `mem_resp`: capture `mem_rdata` into `hold`, go to WR.
- **WR:**
  - Drives `mem_address`=`BUF_BASE`+4·`ptr`, `mem_wdata`=`hold`, `mem_write`=1.
  - On `mem_resp`: `ptr`←(`ptr`+1) mod `BUF_WORDS`. If `ptr` was `BUF_WORDS`-1, set `wrapped`←1.
  - Next state: CLR if `CLEAR_ON_SAMPLE`, otherwise go to the next-index step.
- **CLR:**
  - Drives `mem_address`=`CTR_BASE`+`idx`, `mem_wdata`=0, `mem_write`=1.
  - On `mem_resp`: go to the next-index step.
- **Next-index step:**
  - If `idx`<3: `idx`++, go to RD.
  - If `idx`==3: `samples_taken`++, go to IDLE.
- **Manual trigger while busy:** `sample_now` with `enable`=1 in a non-IDLE state sets `pend`. There is only one pending slot; further pulses are dropped.
- **Bus output rules:**
  - `mem_read` and `mem_write` are never high together.
  - `mem_address` and `mem_wdata` are held stable until `mem_resp`.
  - When no request is asserted, `mem_wdata` and `mem_address` are 0.
- **`enable` falling mid-sample:** the current sample completes, `pend` is cleared, and the block returns to IDLE.
- **Lost counts:** events that hit a counter between its RD and its CLR are lost. This is accepted behaviour.
- **Buffer layout:** sample *k* occupies words 4k..4k+3 modulo `BUF_WORDS`, in counter order 0x50, 0x51, 0x52, 0x53.

## Timing
- **Reset values:** all outputs are 0; state=IDLE; `idx`, `ptr`, `timer`, `hold`, `pend` are 0; `wrapped`=0.
- **Mid-operation reset:** `rst` takes effect on the next edge. In the following cycle all requests are low, with no partial completion.
- **Trigger latency:** a trigger in IDLE in cycle t gives `mem_read`=1 in cycle t+1.
- **Periodic cadence:** with `enable` high from cycle 0 after reset, the first `mem_read` rises at cycle `SAMPLE_PERIOD`.
- **Transaction length:** 1 cycle plus wait states. `mem_resp` may arrive in the first request cycle.
- **Back-to-back requests:** each next request is asserted the cycle after the previous `mem_resp`, with no idle gap.
- **Sample duration:** with zero wait states, a sample keeps `busy` high for 12 cycles (`CLEAR_ON_SAMPLE`=1) or 8 cycles (`CLEAR_ON_SAMPLE`=0).
- **Counter update:** `samples_taken` updates on the edge ending the last transaction. `busy` falls in that same cycle boundary.
- **Serviced pending trigger:** the block spends exactly 1 cycle in IDLE, then starts the next sample.
- **Timer re-arm:** the periodic timer restarts from 0 on each sample start. Periodic samples are therefore spaced `SAMPLE_PERIOD` IDLE cycles apart, not wall-clock cycles.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random inputs → all outputs 0, `busy`=0, no request for 5 cycles after release with `enable`=0.
- **Manual sample:** responder returns 0x11/0x22/0x33/0x44 for 0x50–0x53 with `mem_resp` in the same cycle; pulse `sample_now` → 12 transactions in this order:
  - RD 0x50, WR 0x1000=0x11, WR 0x50=0
  - RD 0x51, WR 0x1004=0x22, WR 0x51=0
  - and so on for 0x52 and 0x53
  - Result: `busy` high 12 cycles, `samples_taken`=1.
- **Periodic:** `SAMPLE_PERIOD`=20, `enable` high from cycle 0 → first `mem_read` at cycle 20. Next sample's `mem_read` occurs 20 IDLE cycles after the first `busy` falls.
- **Wrap:** `BUF_WORDS`=8, three samples → third sample writes 0x1000..0x100C. `wrapped` rises after the 8th buffer write and stays 1.
- **Wait states and pending:** `mem_resp` delayed 3 cycles per transaction → address and request held for 4 cycles each. A `sample_now` pulse during busy → exactly one extra sample after 1 IDLE cycle; `samples_taken`=2.
- **Reset during WR:** assert `rst` while `mem_write`=1 → next cycle `mem_write`=0, `ptr`=0, `samples_taken`=0. A subsequent sample writes to 0x1000.
